// File: rtl/sled_pkg.sv
// Shared types, constants and the hex font for the seven-segment scan controller.
package sled_pkg;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] data;
    } digit_t;

    typedef enum logic {ST_DRIVE, ST_BLANK} state_t;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [3:0] DIG_OFF   = 4'hF;
    localparam digit_t     DIGIT_RST = '{blank: 1'b1, dp: 1'b0, data: 4'h0};

    // Active-low {g..a} pattern for a hex code.
    function automatic logic [6:0] font(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sled_scan_ctrl_if.sv
// Digit write channel (valid/ready) between application logic and the scan controller.
interface sled_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_blank;

    modport master (output wr_valid, wr_addr, wr_data, wr_dp, wr_blank, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_dp, wr_blank, output wr_ready);
endinterface

// File: rtl/sled_seg_encode.sv
// Combinational digit -> active-low segment byte (bit7 = dp, bits6:0 = g..a).
module sled_seg_encode
    import sled_pkg::*;
(
    input  digit_t     digit,
    output logic [7:0] seg
);
    assign seg = digit.blank ? SEG_OFF : {~digit.dp, font(digit.data)};
endmodule

// File: rtl/sled_scan_ctrl.sv
// 4-digit common-anode scan controller with shadow/active digit banks and
// dead-time between slots. Optional feature macro: SLED_BRIGHTNESS_EN
// (adds bright[3:0] and PWM gating of the digit enable during DRIVE).
module sled_scan_ctrl
    import sled_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clock,
    input  logic            rst_n,
    sled_scan_ctrl_if.slave wr,
`ifdef SLED_BRIGHTNESS_EN
    input  logic [3:0]      bright,
`endif
    output logic [7:0]      seg,
    output logic [3:0]      dig,
    output logic            frame_tick
);
    localparam int             PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  DRIVE_LAST = PW'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [PW-1:0]  BLANK_LAST = PW'(BLANK_CYCLES - 1);

    state_t        state, state_nx;
    logic [1:0]    idx, idx_nx;
    logic [PW-1:0] presc, presc_nx;
    logic          run;
    logic          commit;
    logic          accept;
    logic          lit;
    digit_t [3:0]  shadow, active;
    digit_t        cur_digit;
    logic [7:0]    enc_seg;
    logic [3:0]    dig_sel;

    // Slot FSM register; reset parks in slot 3's blank so the first event is a commit.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            idx   <= 2'd3;
            presc <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            presc <= presc_nx;
        end
    end

    // Next state: the prescaler counts within the current phase and clears at each phase end.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        presc_nx = presc + 1'b1;
        case (state)
            ST_DRIVE: if (presc == DRIVE_LAST) begin
                state_nx = ST_BLANK;
                presc_nx = '0;
            end
            ST_BLANK: if (presc == BLANK_LAST) begin
                state_nx = ST_DRIVE;
                presc_nx = '0;
                idx_nx   = idx + 1'b1;
            end
            default: state_nx = ST_BLANK;
        endcase
    end

    assign commit = (state == ST_BLANK) && (idx == 2'd3) && (presc == BLANK_LAST);

    // Goes high on the first edge after reset release; masks ready/tick while in reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    assign wr.wr_ready = run & ~commit;
    assign frame_tick  = run & commit;
    assign accept      = wr.wr_valid & wr.wr_ready;

    // Writes land in the shadow bank; the whole bank is copied to active only at commit.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= {4{DIGIT_RST}};
            active <= {4{DIGIT_RST}};
        end else begin
            if (accept)
                shadow[wr.wr_addr] <= '{blank: wr.wr_blank, dp: wr.wr_dp, data: wr.wr_data};
            if (commit)
                active <= shadow;
        end
    end

`ifdef SLED_BRIGHTNESS_EN
    logic [3:0] pwm, bright_active;

    // Free-running PWM phase and per-frame brightness latch.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pwm           <= '0;
            bright_active <= 4'hF;
        end else begin
            pwm <= pwm + 1'b1;
            if (commit) bright_active <= bright;
        end
    end

    assign lit = (pwm <= bright_active);
`else
    assign lit = 1'b1;
`endif

    assign cur_digit = active[idx];
    assign dig_sel   = ~(4'b0001 << idx);

    sled_seg_encode u_enc (
        .digit (cur_digit),
        .seg   (enc_seg)
    );

    // Registered pins; async reset darkens the display immediately.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dig <= DIG_OFF;
        end else if (state == ST_DRIVE) begin
            seg <= enc_seg;
            dig <= lit ? dig_sel : DIG_OFF;
        end else begin
            seg <= SEG_OFF;
            dig <= DIG_OFF;
        end
    end

endmodule

// File: tb/tb_sled_scan_ctrl.sv
// Scoreboard bench for sled_scan_ctrl (SCAN_DIV=20, BLANK_CYCLES=4).
// At each frame_tick the expected segment byte of all four slots is queued;
// each slot start pops one entry and every DRIVE/BLANK cycle is checked.
module tb_sled_scan_ctrl;
    localparam int SD = 20;
    localparam int BC = 4;
    localparam int DC = SD - BC;

    localparam logic [7:0] FONT_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] seg;
    } slot_t;

    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] bright = 4'hF;
    logic [7:0] seg;
    logic [3:0] dig;
    logic       frame_tick;

    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] shadow_m [4];
    slot_t      q [$];
    slot_t      cur;
    int         r = 0;
    int         rr;
    bit         seen_tick = 1'b0;
    bit         dig_chk_en = 1'b1;

    sled_scan_ctrl_if wif ();

    sled_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .wr         (wif.slave),
`ifdef SLED_BRIGHTNESS_EN
        .bright     (bright),
`endif
        .seg        (seg),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [3:0] d, input logic p, input logic b);
        logic [7:0] f;
        f = FONT_TAB[d];
        return b ? 8'hFF : {~p, f[6:0]};
    endfunction

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clock); #1;
            n++;
        end while (!frame_tick && n < 200);
        chk("tick_seen", frame_tick, 1);
    endtask

    task automatic wr_digit(input logic [1:0] a, input logic [3:0] d, input logic p, input logic b);
        int n;
        n = 0;
        @(negedge clock);
        wif.wr_valid = 1'b1;
        wif.wr_addr  = a;
        wif.wr_data  = d;
        wif.wr_dp    = p;
        wif.wr_blank = b;
        #1;
        while (!wif.wr_ready && n < 200) begin
            @(negedge clock); #1;
            n++;
        end
        chk("wr_accept", wif.wr_ready, 1);
        @(posedge clock);
        shadow_m[a] = exp_seg(d, p, b);
        #1 wif.wr_valid = 1'b0;
    endtask

    // Scoreboard monitor, sampling 1 time unit after each falling edge.
    always @(negedge clock) begin
        logic [3:0] dexp;
        slot_t      e;
        #1;
        if (!rst_n) begin
            q.delete();
            seen_tick = 1'b0;
            r = 0;
        end else begin
            r++;
            chk("dig_onehot", ($countones(~dig) <= 1), 1);
            if (frame_tick) begin
                if (seen_tick) begin
                    chk("frame_period", r, 80);
                    chk("sb_drained", q.size(), 0);
                end
                chk("rdy_commit", wif.wr_ready, 0);
                for (int s = 0; s < 4; s++) begin
                    dexp = ~(4'b0001 << s);
                    e.dig = dexp;
                    e.seg = shadow_m[s];
                    q.push_back(e);
                end
                r = 0;
                seen_tick = 1'b1;
            end else if (seen_tick && r == 81) begin
                chk("tick_gap", r, 80);
            end
            if (seen_tick) begin
                rr = r - 2;
                if (r >= 2 && rr < 4 * SD && (rr % SD) < DC) begin
                    if (rr % SD == 0) begin
                        if (q.size() == 0) chk("sb_underflow", q.size(), 1);
                        else               cur = q.pop_front();
                    end
                    if (dig_chk_en) chk("slot_dig", dig, cur.dig);
                    chk("slot_seg", seg, cur.seg);
                end else begin
                    chk("dark_dig", dig, 4'hF);
                    chk("dark_seg", seg, 8'hFF);
                end
            end
        end
    end

    initial begin
        int n;
        int cnt;
        for (int i = 0; i < 4; i++) shadow_m[i] = 8'hFF;
        wif.wr_valid = 1'b0;
        wif.wr_addr  = '0;
        wif.wr_data  = '0;
        wif.wr_dp    = 1'b0;
        wif.wr_blank = 1'b0;

        // 1: reset state and first commit latency
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        chk("rst_seg", seg, 8'hFF);
        chk("rst_dig", dig, 4'hF);
        chk("rst_tick", frame_tick, 0);
        chk("rst_rdy", wif.wr_ready, 0);
        @(negedge clock);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clock); #1;
            n++;
        end while (!frame_tick && n < 20);
        chk("first_tick_lat", (n <= 4) && frame_tick, 1);

        // 2: basic writes, visible from the next frame
        wr_digit(2'd0, 4'h3, 1'b0, 1'b0);
        wr_digit(2'd1, 4'hA, 1'b1, 1'b0);
        wait_tick();
        wait_tick();

        // 3: mid-frame write (during slot 1) must not tear the current frame
        wait_tick();
        repeat (25) @(negedge clock);
        wr_digit(2'd0, 4'h5, 1'b0, 1'b0);
        wait_tick();
        wait_tick();

        // 5: request raised in the commit cycle is held off one cycle
        wait_tick();
        repeat (80) @(negedge clock);
        wif.wr_valid = 1'b1;
        wif.wr_addr  = 2'd2;
        wif.wr_data  = 4'h7;
        wif.wr_dp    = 1'b1;
        wif.wr_blank = 1'b0;
        #1;
        chk("t5_tick", frame_tick, 1);
        chk("t5_rdy_commit", wif.wr_ready, 0);
        @(negedge clock); #1;
        chk("t5_rdy_after", wif.wr_ready, 1);
        @(posedge clock);
        shadow_m[2] = exp_seg(4'h7, 1'b1, 1'b0);
        #1 wif.wr_valid = 1'b0;
        wait_tick();
        wait_tick();

        // 6: one-clock reset pulse mid-DRIVE of slot 2
        wait_tick();
        repeat (50) @(negedge clock);
        #1;
        chk("t6_pre_dig", dig, 4'b1011);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_seg", seg, 8'hFF);
        chk("t6_rst_dig", dig, 4'hF);
        chk("t6_rst_rdy", wif.wr_ready, 0);
        for (int i = 0; i < 4; i++) shadow_m[i] = 8'hFF;
        @(negedge clock);
        rst_n = 1'b1;
        wait_tick();
        wait_tick();
        wait_tick();

`ifdef SLED_BRIGHTNESS_EN
        // Brightness: bright=3 gives 4 lit clocks per 16 DRIVE clocks
        wr_digit(2'd0, 4'h8, 1'b0, 1'b0);
        bright = 4'd3;
        wait_tick();
        wait_tick();
        dig_chk_en = 1'b0;
        wait_tick();
        @(negedge clock);
        cnt = 0;
        for (int i = 0; i < DC; i++) begin
            @(negedge clock); #1;
            if (dig != 4'hF) cnt++;
        end
        chk("duty_bright3", cnt, 4);
        wait_tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
